// File: rtl/issue_queue_scheduler.sv
// DEPTH-entry issue queue: allocation, tag wakeup, age-matrix oldest-ready select, valid/ready issue.
// Optional ISSUE_QUEUE_PERF_EN adds saturating full-stall and issue counters.
module issue_queue_scheduler #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             dispatch_valid,
  output logic             dispatch_ready,
  input  logic [TAG_W-1:0] dispatch_dest_tag,
  input  logic [TAG_W-1:0] dispatch_src0_tag,
  input  logic             dispatch_src0_rdy,
  input  logic [TAG_W-1:0] dispatch_src1_tag,
  input  logic             dispatch_src1_rdy,
  input  logic             wakeup_valid,
  input  logic [TAG_W-1:0] wakeup_tag,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [IDX_W-1:0] issue_entry,
  output logic [TAG_W-1:0] issue_dest_tag,
  output logic [IDX_W:0]   occupancy
`ifdef ISSUE_QUEUE_PERF_EN
  ,
  output logic [31:0]      perf_full_stall_cnt,
  output logic [31:0]      perf_issue_cnt
`endif
);

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_SELECT = 1'b0,
    ST_HOLD   = 1'b1
  } state_e;

  state_e           state_r;
  state_e           state_nxt_s;

  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] src0_rdy_r;
  logic [DEPTH-1:0] src1_rdy_r;
  logic [TAG_W-1:0] src0_tag_r [DEPTH];
  logic [TAG_W-1:0] src1_tag_r [DEPTH];
  logic [TAG_W-1:0] dest_tag_r [DEPTH];
  logic [DEPTH-1:0] age_r      [DEPTH];

  logic             issue_valid_r;
  logic [IDX_W-1:0] issue_entry_r;
  logic [TAG_W-1:0] issue_dest_tag_r;
  logic [IDX_W:0]   occupancy_r;

  logic             dispatch_ready_s;
  logic             dispatch_fire_s;
  logic             handshake_s;
  logic             hold_s;
  logic [IDX_W-1:0] alloc_idx_s;
  logic [DEPTH-1:0] ready_s;
  logic [DEPTH-1:0] grant_s;
  logic             grant_any_s;
  logic [IDX_W-1:0] grant_idx_s;
  logic             load_s;
  logic             drop_s;

  assign dispatch_ready_s = (occupancy_r < DEPTH_C);
  assign dispatch_fire_s  = dispatch_valid && dispatch_ready_s;
  assign handshake_s      = issue_valid_r && issue_ready;
  assign hold_s           = (state_r == ST_HOLD);

  assign dispatch_ready   = dispatch_ready_s;
  assign issue_valid      = issue_valid_r;
  assign issue_entry      = issue_entry_r;
  assign issue_dest_tag   = issue_dest_tag_r;
  assign occupancy        = occupancy_r;

  // Lowest-index free entry, from pre-edge valid bits.
  always_comb begin
    alloc_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      alloc_idx_s = valid_r[i] ? alloc_idx_s : IDX_W'(i);
    end
  end

  // Ready vector; the entry currently held on the issue port never re-competes.
  always_comb begin
    ready_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_s[i] = valid_r[i] & src0_rdy_r[i] & src1_rdy_r[i]
                 & ~(hold_s && (issue_entry_r == IDX_W'(i)));
    end
  end

  // Oldest-ready grant: an entry wins when no older ready entry exists.
  always_comb begin
    logic [DEPTH-1:0] older_v;
    older_v = '0;
    grant_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      older_v = '0;
      for (int j = 0; j < DEPTH; j++) begin
        older_v[j] = ready_s[j] & age_r[j][i] & (j != i);
      end
      grant_s[i] = ready_s[i] & ~(|older_v);
    end
  end

  // One-hot grant to index.
  always_comb begin
    grant_any_s = |grant_s;
    grant_idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant_idx_s = grant_s[i] ? IDX_W'(i) : grant_idx_s;
    end
  end

  // Issue FSM next-state and latch/drop decisions.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    drop_s      = 1'b0;
    if (flush) begin
      state_nxt_s = ST_SELECT;
      drop_s      = 1'b1;
    end else begin
      case (state_r)
        ST_SELECT: begin
          if (grant_any_s) begin
            state_nxt_s = ST_HOLD;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = ST_SELECT;
          end
        end
        ST_HOLD: begin
          if (issue_ready && grant_any_s) begin
            state_nxt_s = ST_HOLD;
            load_s      = 1'b1;
          end else if (issue_ready) begin
            state_nxt_s = ST_SELECT;
            drop_s      = 1'b1;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
        default: begin
          state_nxt_s = ST_SELECT;
          drop_s      = 1'b1;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_SELECT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered issue port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid_r    <= 1'b0;
      issue_entry_r    <= '0;
      issue_dest_tag_r <= '0;
    end else if (flush) begin
      issue_valid_r    <= 1'b0;
      issue_entry_r    <= '0;
      issue_dest_tag_r <= '0;
    end else if (load_s) begin
      issue_valid_r    <= 1'b1;
      issue_entry_r    <= grant_idx_s;
      issue_dest_tag_r <= dest_tag_r[grant_idx_s];
    end else if (drop_s) begin
      issue_valid_r    <= 1'b0;
    end
  end

  // Entry storage: wakeup, insert with bypass, and retire on issue handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r    <= '0;
      src0_rdy_r <= '0;
      src1_rdy_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        src0_tag_r[i] <= '0;
        src1_tag_r[i] <= '0;
        dest_tag_r[i] <= '0;
        age_r[i]      <= '0;
      end
    end else if (flush) begin
      valid_r    <= '0;
      src0_rdy_r <= '0;
      src1_rdy_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wakeup_valid && valid_r[i] && (src0_tag_r[i] == wakeup_tag)) begin
          src0_rdy_r[i] <= 1'b1;
        end
        if (wakeup_valid && valid_r[i] && (src1_tag_r[i] == wakeup_tag)) begin
          src1_rdy_r[i] <= 1'b1;
        end
      end
      if (dispatch_fire_s) begin
        valid_r[alloc_idx_s]    <= 1'b1;
        dest_tag_r[alloc_idx_s] <= dispatch_dest_tag;
        src0_tag_r[alloc_idx_s] <= dispatch_src0_tag;
        src1_tag_r[alloc_idx_s] <= dispatch_src1_tag;
        src0_rdy_r[alloc_idx_s] <= dispatch_src0_rdy
                                 | (wakeup_valid && (dispatch_src0_tag == wakeup_tag));
        src1_rdy_r[alloc_idx_s] <= dispatch_src1_rdy
                                 | (wakeup_valid && (dispatch_src1_tag == wakeup_tag));
        age_r[alloc_idx_s]      <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          age_r[j][alloc_idx_s] <= (IDX_W'(j) != alloc_idx_s) ? valid_r[j] : 1'b0;
        end
      end
      // Retirement is applied last so it overrides any age bit just set toward it.
      if (handshake_s) begin
        valid_r[issue_entry_r] <= 1'b0;
        age_r[issue_entry_r]   <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          age_r[j][issue_entry_r] <= 1'b0;
        end
      end
    end
  end

  // Occupancy tracks dispatches minus issue handshakes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy_r <= '0;
    end else if (flush) begin
      occupancy_r <= '0;
    end else begin
      case ({dispatch_fire_s, handshake_s})
        2'b10:   occupancy_r <= occupancy_r + (IDX_W+1)'(1);
        2'b01:   occupancy_r <= occupancy_r - (IDX_W+1)'(1);
        default: occupancy_r <= occupancy_r;
      endcase
    end
  end

`ifdef ISSUE_QUEUE_PERF_EN
  logic [31:0] perf_full_stall_cnt_r;
  logic [31:0] perf_issue_cnt_r;

  assign perf_full_stall_cnt = perf_full_stall_cnt_r;
  assign perf_issue_cnt      = perf_issue_cnt_r;

  // Saturating performance counters; intentionally survive flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_full_stall_cnt_r <= 32'd0;
      perf_issue_cnt_r      <= 32'd0;
    end else begin
      if (dispatch_valid && !dispatch_ready_s && (perf_full_stall_cnt_r != 32'hFFFF_FFFF)) begin
        perf_full_stall_cnt_r <= perf_full_stall_cnt_r + 32'd1;
      end
      if (handshake_s && (perf_issue_cnt_r != 32'hFFFF_FFFF)) begin
        perf_issue_cnt_r <= perf_issue_cnt_r + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_issue_queue_scheduler.sv
// Self-checking bench for issue_queue_scheduler: directed scenarios plus random traffic
// checked against a sequence-number based queue model.
module tb_issue_queue_scheduler;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
  localparam int IDX_W = 2;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             dispatch_valid;
  logic             dispatch_ready;
  logic [TAG_W-1:0] dispatch_dest_tag;
  logic [TAG_W-1:0] dispatch_src0_tag;
  logic             dispatch_src0_rdy;
  logic [TAG_W-1:0] dispatch_src1_tag;
  logic             dispatch_src1_rdy;
  logic             wakeup_valid;
  logic [TAG_W-1:0] wakeup_tag;
  logic             issue_valid;
  logic             issue_ready;
  logic [IDX_W-1:0] issue_entry;
  logic [TAG_W-1:0] issue_dest_tag;
  logic [IDX_W:0]   occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: age is an insertion sequence number, oldest = smallest.
  bit m_valid [DEPTH];
  bit m_s0r   [DEPTH];
  bit m_s1r   [DEPTH];
  int m_s0t   [DEPTH];
  int m_s1t   [DEPTH];
  int m_dest  [DEPTH];
  int m_seq   [DEPTH];
  int seq_ctr;
  bit m_iv;
  int m_ie;
  int m_itag;
  int m_occ;

  issue_queue_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .dispatch_valid    (dispatch_valid),
    .dispatch_ready    (dispatch_ready),
    .dispatch_dest_tag (dispatch_dest_tag),
    .dispatch_src0_tag (dispatch_src0_tag),
    .dispatch_src0_rdy (dispatch_src0_rdy),
    .dispatch_src1_tag (dispatch_src1_tag),
    .dispatch_src1_rdy (dispatch_src1_rdy),
    .wakeup_valid      (wakeup_valid),
    .wakeup_tag        (wakeup_tag),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_entry       (issue_entry),
    .issue_dest_tag    (issue_dest_tag),
    .occupancy         (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0; m_s0r[i] = 1'b0; m_s1r[i] = 1'b0;
      m_s0t[i] = 0; m_s1t[i] = 0; m_dest[i] = 0; m_seq[i] = 0;
    end
    seq_ctr = 0; m_iv = 1'b0; m_ie = 0; m_itag = 0; m_occ = 0;
  endtask

  task automatic model_step();
    int w;
    int alloc;
    int hs_idx;
    bit hs;
    bit fire;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      m_iv = 1'b0; m_ie = 0; m_itag = 0; m_occ = 0;
      return;
    end
    hs = m_iv && issue_ready;
    hs_idx = m_ie;
    w = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && m_s0r[i] && m_s1r[i] && !(m_iv && m_ie == i)) begin
        if (w < 0 || m_seq[i] < m_seq[w]) w = i;
      end
    end
    fire = dispatch_valid && (m_occ < DEPTH);
    alloc = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_valid[i] && alloc < 0) alloc = i;
    end
    if (!m_iv || hs) begin
      if (w >= 0) begin
        m_iv = 1'b1; m_ie = w; m_itag = m_dest[w];
      end else begin
        m_iv = 1'b0;
      end
    end
    if (wakeup_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m_valid[i] && m_s0t[i] == int'(wakeup_tag)) m_s0r[i] = 1'b1;
        if (m_valid[i] && m_s1t[i] == int'(wakeup_tag)) m_s1r[i] = 1'b1;
      end
    end
    if (fire) begin
      m_valid[alloc] = 1'b1;
      m_dest[alloc]  = int'(dispatch_dest_tag);
      m_s0t[alloc]   = int'(dispatch_src0_tag);
      m_s1t[alloc]   = int'(dispatch_src1_tag);
      m_s0r[alloc]   = dispatch_src0_rdy || (wakeup_valid && dispatch_src0_tag == wakeup_tag);
      m_s1r[alloc]   = dispatch_src1_rdy || (wakeup_valid && dispatch_src1_tag == wakeup_tag);
      m_seq[alloc]   = seq_ctr;
      seq_ctr++;
      m_occ++;
    end
    if (hs) begin
      m_valid[hs_idx] = 1'b0;
      m_occ--;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    flush = 1'b0; dispatch_valid = 1'b0;
    dispatch_dest_tag = '0; dispatch_src0_tag = '0; dispatch_src1_tag = '0;
    dispatch_src0_rdy = 1'b0; dispatch_src1_rdy = 1'b0;
    wakeup_valid = 1'b0; wakeup_tag = '0; issue_ready = 1'b0;
  endtask

  task automatic set_dispatch(input logic [TAG_W-1:0] dest, input logic [TAG_W-1:0] s0,
                              input logic r0, input logic [TAG_W-1:0] s1, input logic r1);
    dispatch_valid = 1'b1; dispatch_dest_tag = dest;
    dispatch_src0_tag = s0; dispatch_src0_rdy = r0;
    dispatch_src1_tag = s1; dispatch_src1_rdy = r1;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    model_reset();
    #2;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid: got %0b want 0", issue_valid); end
    n_checks++; if (issue_entry !== 2'd0) begin n_fail++; $display("FAIL reset_issue_entry: got %0d want 0", issue_entry); end
    n_checks++; if (issue_dest_tag !== 6'd0) begin n_fail++; $display("FAIL reset_dest_tag: got %0d want 0", issue_dest_tag); end
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    n_checks++; if (dispatch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_dispatch_ready: got %0b want 1", dispatch_ready); end
    do_reset();
  endtask

  task automatic test_age_order();
    do_reset();
    set_dispatch(6'd1, 6'd20, 1'b0, 6'd21, 1'b1); tick();
    set_dispatch(6'd2, 6'd22, 1'b1, 6'd23, 1'b1); tick();
    drive_idle();
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL age_new_not_visible: got %0b want 0", issue_valid); end
    tick();
    n_checks++; if (issue_valid !== 1'b1 || issue_entry !== 2'd1 || issue_dest_tag !== 6'd2) begin
      n_fail++; $display("FAIL age_first_issue: got v=%0b e=%0d t=%0d want v=1 e=1 t=2", issue_valid, issue_entry, issue_dest_tag); end
    wakeup_valid = 1'b1; wakeup_tag = 6'd20; issue_ready = 1'b1; tick();
    n_checks++; if (issue_valid !== 1'b0 || occupancy !== 3'd1) begin
      n_fail++; $display("FAIL age_after_b: got v=%0b occ=%0d want v=0 occ=1", issue_valid, occupancy); end
    wakeup_valid = 1'b0; tick();
    n_checks++; if (issue_valid !== 1'b1 || issue_entry !== 2'd0 || issue_dest_tag !== 6'd1) begin
      n_fail++; $display("FAIL age_second_issue: got v=%0b e=%0d t=%0d want v=1 e=0 t=1", issue_valid, issue_entry, issue_dest_tag); end
    tick();
    n_checks++; if (issue_valid !== 1'b0 || occupancy !== 3'd0) begin
      n_fail++; $display("FAIL age_drain: got v=%0b occ=%0d want v=0 occ=0", issue_valid, occupancy); end
  endtask

  task automatic test_back_to_back();
    int exp_occ;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_dispatch(6'(5 + k), 6'd0, 1'b1, 6'd0, 1'b1); tick();
    end
    drive_idle();
    n_checks++; if (issue_valid !== 1'b1 || issue_dest_tag !== 6'd5 || occupancy !== 3'd3) begin
      n_fail++; $display("FAIL b2b_start: got v=%0b t=%0d occ=%0d want v=1 t=5 occ=3", issue_valid, issue_dest_tag, occupancy); end
    issue_ready = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      exp_occ = 3 - k;
      n_checks++; if (issue_valid !== 1'b1 || issue_dest_tag !== 6'(5 + k) || issue_entry !== 2'(k) || occupancy !== 3'(exp_occ)) begin
        n_fail++; $display("FAIL b2b_step%0d: got v=%0b e=%0d t=%0d occ=%0d want v=1 e=%0d t=%0d occ=%0d",
                           k, issue_valid, issue_entry, issue_dest_tag, occupancy, k, 5 + k, exp_occ); end
    end
    tick();
    n_checks++; if (issue_valid !== 1'b0 || occupancy !== 3'd0) begin
      n_fail++; $display("FAIL b2b_end: got v=%0b occ=%0d want v=0 occ=0", issue_valid, occupancy); end
  endtask

  task automatic test_hold_stability();
    do_reset();
    set_dispatch(6'd10, 6'd30, 1'b0, 6'd0, 1'b1); tick();
    set_dispatch(6'd11, 6'd31, 1'b0, 6'd0, 1'b1); tick();
    set_dispatch(6'd12, 6'd0, 1'b1, 6'd0, 1'b1); tick();
    drive_idle(); tick();
    for (int k = 0; k < 4; k++) begin
      wakeup_valid = (k == 0); wakeup_tag = 6'd30; tick();
      n_checks++; if (issue_valid !== 1'b1 || issue_entry !== 2'd2 || issue_dest_tag !== 6'd12) begin
        n_fail++; $display("FAIL hold_cycle%0d: got v=%0b e=%0d t=%0d want v=1 e=2 t=12", k, issue_valid, issue_entry, issue_dest_tag); end
    end
    drive_idle(); issue_ready = 1'b1; tick();
    n_checks++; if (issue_valid !== 1'b1 || issue_entry !== 2'd0 || issue_dest_tag !== 6'd10 || occupancy !== 3'd2) begin
      n_fail++; $display("FAIL hold_next_older: got v=%0b e=%0d t=%0d occ=%0d want v=1 e=0 t=10 occ=2", issue_valid, issue_entry, issue_dest_tag, occupancy); end
    tick();
    n_checks++; if (issue_valid !== 1'b0 || occupancy !== 3'd1) begin
      n_fail++; $display("FAIL hold_drain: got v=%0b occ=%0d want v=0 occ=1", issue_valid, occupancy); end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_dispatch(6'(20 + k), 6'(40 + k), 1'b0, 6'd0, 1'b1); tick();
    end
    n_checks++; if (dispatch_ready !== 1'b0 || occupancy !== 3'd4) begin
      n_fail++; $display("FAIL full_state: got rdy=%0b occ=%0d want rdy=0 occ=4", dispatch_ready, occupancy); end
    set_dispatch(6'd30, 6'd0, 1'b1, 6'd0, 1'b1);
    wakeup_valid = 1'b1; wakeup_tag = 6'd41; tick();
    n_checks++; if (occupancy !== 3'd4 || issue_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_reject: got occ=%0d v=%0b want occ=4 v=0", occupancy, issue_valid); end
    wakeup_valid = 1'b0; tick();
    n_checks++; if (issue_valid !== 1'b1 || issue_entry !== 2'd1 || issue_dest_tag !== 6'd21 || dispatch_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_issue: got v=%0b e=%0d t=%0d rdy=%0b want v=1 e=1 t=21 rdy=0", issue_valid, issue_entry, issue_dest_tag, dispatch_ready); end
    issue_ready = 1'b1; tick();
    n_checks++; if (issue_valid !== 1'b0 || occupancy !== 3'd3 || dispatch_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_after_hs: got v=%0b occ=%0d rdy=%0b want v=0 occ=3 rdy=1", issue_valid, occupancy, dispatch_ready); end
    issue_ready = 1'b0; tick();
    n_checks++; if (occupancy !== 3'd4 || dispatch_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_refill: got occ=%0d rdy=%0b want occ=4 rdy=0", occupancy, dispatch_ready); end
    drive_idle(); tick();
    n_checks++; if (issue_valid !== 1'b1 || issue_entry !== 2'd1 || issue_dest_tag !== 6'd30) begin
      n_fail++; $display("FAIL full_reuse_slot: got v=%0b e=%0d t=%0d want v=1 e=1 t=30", issue_valid, issue_entry, issue_dest_tag); end
  endtask

  task automatic test_bypass();
    do_reset();
    set_dispatch(6'd50, 6'd9, 1'b0, 6'd0, 1'b1);
    wakeup_valid = 1'b1; wakeup_tag = 6'd9; tick();
    drive_idle();
    n_checks++; if (issue_valid !== 1'b0 || occupancy !== 3'd1) begin
      n_fail++; $display("FAIL bypass_t1: got v=%0b occ=%0d want v=0 occ=1", issue_valid, occupancy); end
    tick();
    n_checks++; if (issue_valid !== 1'b1 || issue_entry !== 2'd0 || issue_dest_tag !== 6'd50) begin
      n_fail++; $display("FAIL bypass_t2: got v=%0b e=%0d t=%0d want v=1 e=0 t=50", issue_valid, issue_entry, issue_dest_tag); end
    issue_ready = 1'b1; tick();
    issue_ready = 1'b0;
    set_dispatch(6'd51, 6'd9, 1'b0, 6'd0, 1'b1);
    wakeup_valid = 1'b1; wakeup_tag = 6'd8; tick();
    drive_idle(); tick(); tick();
    n_checks++; if (issue_valid !== 1'b0 || occupancy !== 3'd1) begin
      n_fail++; $display("FAIL bypass_wrong_tag: got v=%0b occ=%0d want v=0 occ=1", issue_valid, occupancy); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_dispatch(6'(1 + k), 6'd0, 1'b1, 6'd0, 1'b1); tick();
    end
    n_checks++; if (issue_valid !== 1'b1 || issue_entry !== 2'd0 || occupancy !== 3'd3) begin
      n_fail++; $display("FAIL flush_pre: got v=%0b e=%0d occ=%0d want v=1 e=0 occ=3", issue_valid, issue_entry, occupancy); end
    flush = 1'b1; issue_ready = 1'b1; set_dispatch(6'd60, 6'd0, 1'b1, 6'd0, 1'b1);
    #1;
    n_checks++; if (dispatch_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_ungated: got %0b want 1", dispatch_ready); end
    tick();
    n_checks++; if (issue_valid !== 1'b0 || occupancy !== 3'd0 || dispatch_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_edge: got v=%0b occ=%0d rdy=%0b want v=0 occ=0 rdy=1", issue_valid, occupancy, dispatch_ready); end
    drive_idle(); set_dispatch(6'd44, 6'd0, 1'b1, 6'd0, 1'b1); tick();
    drive_idle(); tick();
    n_checks++; if (issue_valid !== 1'b1 || issue_entry !== 2'd0 || issue_dest_tag !== 6'd44 || occupancy !== 3'd1) begin
      n_fail++; $display("FAIL flush_redispatch: got v=%0b e=%0d t=%0d occ=%0d want v=1 e=0 t=44 occ=1", issue_valid, issue_entry, issue_dest_tag, occupancy); end
    issue_ready = 1'b1; tick();
    n_checks++; if (issue_valid !== 1'b0 || occupancy !== 3'd0) begin
      n_fail++; $display("FAIL flush_drain: got v=%0b occ=%0d want v=0 occ=0", issue_valid, occupancy); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_dispatch(6'd70, 6'd0, 1'b1, 6'd0, 1'b1); tick();
    drive_idle(); tick();
    n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got v=%0b want 1", issue_valid); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (issue_valid !== 1'b0 || occupancy !== 3'd0) begin
      n_fail++; $display("FAIL areset_drop: got v=%0b occ=%0d want v=0 occ=0", issue_valid, occupancy); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      flush             = ($urandom_range(0, 49) == 0);
      dispatch_valid    = ($urandom_range(0, 1) == 1);
      dispatch_dest_tag = 6'($urandom_range(0, 63));
      dispatch_src0_tag = 6'($urandom_range(0, 7));
      dispatch_src1_tag = 6'($urandom_range(0, 7));
      dispatch_src0_rdy = ($urandom_range(0, 2) != 0);
      dispatch_src1_rdy = ($urandom_range(0, 2) != 0);
      wakeup_valid      = ($urandom_range(0, 1) == 1);
      wakeup_tag        = 6'($urandom_range(0, 7));
      issue_ready       = ($urandom_range(0, 4) < 3);
      tick();
      n_checks++; if (issue_valid !== m_iv) begin
        n_fail++; $display("FAIL rand_issue_valid c=%0d: got %0b want %0b", c, issue_valid, m_iv); end
      n_checks++; if (occupancy !== 3'(m_occ) || dispatch_ready !== (m_occ < DEPTH)) begin
        n_fail++; $display("FAIL rand_occupancy c=%0d: got occ=%0d rdy=%0b want occ=%0d", c, occupancy, dispatch_ready, m_occ); end
      if (m_iv) begin
        n_checks++; if (issue_entry !== 2'(m_ie) || issue_dest_tag !== 6'(m_itag)) begin
          n_fail++; $display("FAIL rand_issue_sel c=%0d: got e=%0d t=%0d want e=%0d t=%0d", c, issue_entry, issue_dest_tag, m_ie, m_itag); end
      end
    end
    drive_idle();
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    test_reset();
    test_age_order();
    test_back_to_back();
    test_hold_stability();
    test_full();
    test_bypass();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
